// File: rtl/int_issue_queue_pkg.sv
// int_issue_queue_pkg: shared opcode, entry type and age compare for the integer issue queue
package int_issue_queue_pkg;
  typedef enum logic [5:0] {
    INT_NOP, INT_ADD, INT_SUB, INT_AND, INT_OR, INT_XOR, INT_SLL, INT_SRL, INT_SRA,
    INT_SLT, INT_SLTU, INT_LUI, INT_AUIPC, INT_BEQ, INT_BNE, INT_BLT, INT_BGE, INT_JAL, INT_JALR
  } OPCode_INT;
  typedef struct packed {
    logic valid;
    OPCode_INT opcode;
    logic [5:0] tagA;
    logic [5:0] tagB;
    logic availA;
    logic availB;
    logic [5:0] tagDst;
    logic [4:0] nmDst;
    logic [5:0] sqN;
  } IQEntry;
  function automatic logic is_older(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] d;
    d = a - b;
    return d[5];
  endfunction
endpackage

// File: rtl/int_issue_queue_age_select.sv
// iq_age_select: binary tree picking the oldest requesting entry, lower index wins ties
module iq_age_select import int_issue_queue_pkg::*; #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]      req,
  input  logic [SIZE-1:0][5:0] sqn,
  output logic [SIZE-1:0]      grant,
  output logic                 found
);
  localparam int IW = $clog2(SIZE);
  localparam int NODES = 2 * SIZE - 1;
  logic [NODES-1:0] nv;
  logic [5:0] ns [NODES];
  logic [IW-1:0] ni [NODES];
  always_comb begin
    nv = '0;
    for (int n = 0; n < NODES; n++) begin
      ns[n] = '0;
      ni[n] = '0;
    end
    for (int i = 0; i < SIZE; i++) begin
      nv[SIZE-1+i] = req[i];
      ns[SIZE-1+i] = sqn[i];
      ni[SIZE-1+i] = IW'(i);
    end
    // leaves sit left-to-right in index order, so a left win on equal age keeps the lower index
    for (int n = SIZE - 2; n >= 0; n--) begin
      nv[n] = nv[2*n+1] | nv[2*n+2];
      ns[n] = (!nv[2*n+2] || (nv[2*n+1] && !is_older(ns[2*n+2], ns[2*n+1]))) ? ns[2*n+1] : ns[2*n+2];
      ni[n] = (!nv[2*n+2] || (nv[2*n+1] && !is_older(ns[2*n+2], ns[2*n+1]))) ? ni[2*n+1] : ni[2*n+2];
    end
    grant = '0;
    if (nv[0]) grant[ni[0]] = 1'b1;
  end
  assign found = nv[0];
endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: out-of-order issue queue and oldest-ready scheduler for the integer ALU
module int_issue_queue import int_issue_queue_pkg::*; #(
  parameter int SIZE   = 8,
  parameter int NUM_WB = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IN_enqValid,
  input  OPCode_INT              IN_enqOpcode,
  input  logic [5:0]             IN_enqTagA,
  input  logic [5:0]             IN_enqTagB,
  input  logic                   IN_enqAvailA,
  input  logic                   IN_enqAvailB,
  input  logic [5:0]             IN_enqTagDst,
  input  logic [4:0]             IN_enqNmDst,
  input  logic [5:0]             IN_enqSqN,
  input  logic [NUM_WB-1:0]      IN_resValid,
  input  logic [NUM_WB-1:0][5:0] IN_resTag,
  input  logic                   IN_invalidate,
  input  logic [5:0]             IN_invalidateSqN,
  input  logic                   IN_stall,
  output logic                   OUT_full,
  output logic                   OUT_valid,
  output OPCode_INT              OUT_opcode,
  output logic [5:0]             OUT_tagA,
  output logic [5:0]             OUT_tagB,
  output logic [5:0]             OUT_tagDst,
  output logic [4:0]             OUT_nmDst,
  output logic [5:0]             OUT_sqN
);
  IQEntry q [SIZE];
  IQEntry nxt [SIZE];
  IQEntry enq_e, sel;
  logic [SIZE-1:0] free, enq_oh, flush, req, grant, vld_n;
  logic [SIZE-1:0][5:0] sqn;
  logic found, issue, enq_take;
  function automatic logic hit(input logic [NUM_WB-1:0] v, input logic [NUM_WB-1:0][5:0] t,
                               input logic [5:0] tag);
    hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++) hit |= v[p] && (t[p] == tag);
  endfunction
  always_comb begin
    free = '0;
    flush = '0;
    req = '0;
    sqn = '0;
    for (int i = 0; i < SIZE; i++) begin
      free[i] = !q[i].valid;
      flush[i] = IN_invalidate && q[i].valid && is_older(IN_invalidateSqN, q[i].sqN);
      req[i] = q[i].valid && q[i].availA && q[i].availB && !flush[i];
      sqn[i] = q[i].sqN;
    end
  end
  iq_age_select #(.SIZE(SIZE)) u_sel (
    .req  (req),
    .sqn  (sqn),
    .grant(grant),
    .found(found)
  );
  assign enq_oh = free & (~free + SIZE'(1));
  assign enq_take = IN_enqValid && !OUT_full &&
                    !(IN_invalidate && is_older(IN_invalidateSqN, IN_enqSqN));
  assign issue = !IN_stall && found;
  always_comb begin
    enq_e = '{valid: 1'b1, opcode: IN_enqOpcode, tagA: IN_enqTagA, tagB: IN_enqTagB,
              availA: IN_enqAvailA | hit(IN_resValid, IN_resTag, IN_enqTagA),
              availB: IN_enqAvailB | hit(IN_resValid, IN_resTag, IN_enqTagB),
              tagDst: IN_enqTagDst, nmDst: IN_enqNmDst, sqN: IN_enqSqN};
    sel = '0;
    for (int i = 0; i < SIZE; i++) if (grant[i]) sel = q[i];
  end
  always_comb begin
    vld_n = '0;
    for (int i = 0; i < SIZE; i++) begin
      nxt[i] = q[i];
      nxt[i].availA = q[i].availA | hit(IN_resValid, IN_resTag, q[i].tagA);
      nxt[i].availB = q[i].availB | hit(IN_resValid, IN_resTag, q[i].tagB);
      if (flush[i] || (issue && grant[i])) nxt[i].valid = 1'b0;
      if (enq_take && enq_oh[i]) nxt[i] = enq_e;
      vld_n[i] = nxt[i].valid;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '{default: '0};
      OUT_full <= 1'b0;
      OUT_valid <= 1'b0;
      OUT_opcode <= INT_NOP;
      OUT_tagA <= '0;
      OUT_tagB <= '0;
      OUT_tagDst <= '0;
      OUT_nmDst <= '0;
      OUT_sqN <= '0;
    end else begin
      q <= nxt;
      OUT_full <= &vld_n;
      if (!IN_stall) begin
        OUT_valid <= sel.valid && sel.availA && sel.availB;
        if (found) begin
          OUT_opcode <= sel.opcode;
          OUT_tagA <= sel.tagA;
          OUT_tagB <= sel.tagB;
          OUT_tagDst <= sel.tagDst;
          OUT_nmDst <= sel.nmDst;
          OUT_sqN <= sel.sqN;
        end
      end else if (IN_invalidate && OUT_valid && is_older(IN_invalidateSqN, OUT_sqN)) begin
        OUT_valid <= 1'b0;
      end
    end
  end
endmodule
